// File: rtl/hertz_ctrl_gen.sv
// hertz_ctrl_gen: control source for the LED counter path.
// Two push-buttons are synchronized and debounced. They drive an INIT/RUN/PAUSE
// controller that gates a selectable-rate square-wave generator.
module hertz_ctrl_gen #(
  parameter int DIV         = 50_000_000,
  parameter int DB_CYCLES   = 1_000_000,
  parameter int INIT_CYCLES = 4
) (
  input  logic       clk50,
  input  logic       sys_rst_n,
  input  logic       btn_init,
  input  logic       btn_run,
  input  logic [1:0] speed_sel,
  output logic       sys_init_ctrl,
  output logic       hertz_clk,
  output logic       tick,
  output logic       running
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam int DW  = $clog2(DIV / 2);
  localparam int HW  = $clog2(INIT_CYCLES + 1);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(INIT_CYCLES - 1);
  localparam logic [31:0]    DIV_W     = 32'(DIV);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // Button lanes: bit 0 is the init button, bit 1 is the run/pause button.
  logic [1:0]     btn_raw_s;
  logic [1:0]     sync1_q;
  logic [1:0]     sync2_q;
  logic [1:0]     deb_q;
  logic [1:0]     deb_d;
  logic [1:0]     press_q;
  logic [1:0]     press_d;
  logic [DBW-1:0] dbc_q [2];
  logic [DBW-1:0] dbc_d [2];

  state_e         state_q;
  state_e         state_d;
  logic [HW-1:0]  hold_q;
  logic [HW-1:0]  hold_d;

  logic [DW-1:0]  div_q;
  logic [DW-1:0]  div_d;
  logic [DW-1:0]  half_m1_s;
  logic           wrap_s;
  logic [1:0]     spd_q;
  logic [1:0]     spd_d;
  logic           hz_q;
  logic           hz_d;
  logic           tick_q;
  logic           tick_d;
  logic           init_q;
  logic           run_q;

  assign btn_raw_s = {btn_run, btn_init};

  // Debounce: the level flips only after it has disagreed with the synced input for DB_CYCLES edges.
  always_comb begin
    deb_d   = deb_q;
    press_d = 2'b00;
    for (int b = 0; b < 2; b++) begin
      dbc_d[b] = '0;
      if (sync2_q[b] != deb_q[b]) begin
        if (dbc_q[b] == DB_LAST) begin
          deb_d[b]   = sync2_q[b];
          press_d[b] = sync2_q[b];
          dbc_d[b]   = '0;
        end else begin
          dbc_d[b] = dbc_q[b] + DBW'(1);
        end
      end else begin
        dbc_d[b] = '0;
      end
    end
  end

  // Synchronizer chain, debounce counters and press-event pulses.
  always_ff @(posedge clk50) begin
    if (!sys_rst_n) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      deb_q    <= 2'b00;
      press_q  <= 2'b00;
      dbc_q[0] <= '0;
      dbc_q[1] <= '0;
    end else begin
      sync1_q  <= btn_raw_s;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      press_q  <= press_d;
      dbc_q[0] <= dbc_d[0];
      dbc_q[1] <= dbc_d[1];
    end
  end

  // Controller next state: an init press always wins and restarts the hold.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (press_q[0]) begin
      state_d = ST_INIT;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_RUN;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        ST_RUN: begin
          if (press_q[1]) begin
            state_d = ST_PAUSE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (press_q[1]) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        default: begin
          state_d = ST_INIT;
          hold_d  = '0;
        end
      endcase
    end
  end

  // Controller state and INIT hold counter.
  always_ff @(posedge clk50) begin
    if (!sys_rst_n) begin
      state_q <= ST_INIT;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Last count of the current half-period, derived from the latched speed only.
  assign half_m1_s = DW'(((DIV_W >> spd_q) >> 1) - 32'd1);
  assign wrap_s    = (div_q == half_m1_s);

  // Divider next state: cleared in INIT, advancing in RUN, frozen in PAUSE.
  always_comb begin
    div_d  = div_q;
    hz_d   = hz_q;
    spd_d  = spd_q;
    tick_d = 1'b0;
    if ((state_q == ST_INIT) || (state_d == ST_INIT)) begin
      div_d = '0;
      hz_d  = 1'b0;
      spd_d = speed_sel;
    end else if (state_q == ST_RUN) begin
      if (wrap_s) begin
        div_d  = '0;
        hz_d   = ~hz_q;
        tick_d = ~hz_q;
        spd_d  = speed_sel;
      end else begin
        div_d = div_q + DW'(1);
      end
    end else begin
      div_d = div_q;
    end
  end

  // Divider state and registered outputs.
  always_ff @(posedge clk50) begin
    if (!sys_rst_n) begin
      div_q  <= '0;
      hz_q   <= 1'b0;
      spd_q  <= 2'd0;
      tick_q <= 1'b0;
      init_q <= 1'b1;
      run_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      hz_q   <= hz_d;
      spd_q  <= spd_d;
      tick_q <= tick_d;
      init_q <= (state_d == ST_INIT);
      run_q  <= (state_d == ST_RUN);
    end
  end

  assign sys_init_ctrl = init_q;
  assign hertz_clk     = hz_q;
  assign tick          = tick_q;
  assign running       = run_q;

endmodule

// File: tb/tb_hertz_ctrl_gen.sv
// Testbench for hertz_ctrl_gen: directed vector table plus randomized buttons,
// with a cycle-level behavioural model checked on every cycle.
module tb_hertz_ctrl_gen;

  localparam int DIV  = 16;
  localparam int DB   = 4;
  localparam int INIT = 3;

  localparam int M_INIT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic       clk50 = 1'b0;
  logic       sys_rst_n;
  logic       btn_init;
  logic       btn_run;
  logic [1:0] speed_sel;
  logic       sys_init_ctrl;
  logic       hertz_clk;
  logic       tick;
  logic       running;

  hertz_ctrl_gen #(
    .DIV        (DIV),
    .DB_CYCLES  (DB),
    .INIT_CYCLES(INIT)
  ) dut (
    .clk50        (clk50),
    .sys_rst_n    (sys_rst_n),
    .btn_init     (btn_init),
    .btn_run      (btn_run),
    .speed_sel    (speed_sel),
    .sys_init_ctrl(sys_init_ctrl),
    .hertz_clk    (hertz_clk),
    .tick         (tick),
    .running      (running)
  );

  always #5 clk50 = ~clk50;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Behavioural model state
  int   m_mode;
  int   m_left;
  int   m_elapsed;
  int   m_spd;
  logic m_hz;
  logic m_tick;
  logic m_deb  [2];
  int   m_run  [2];
  logic m_hist [2][2];
  logic m_ev   [2];

  typedef struct {
    logic       rst_n;
    logic       bi;
    logic       br;
    logic [1:0] spd;
    int         ncyc;
    logic [3:0] exp;   // {sys_init_ctrl, hertz_clk, tick, running}
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic bi, input logic br,
                              input logic [1:0] s, input int n, input logic [3:0] e);
    vec_t v;
    v.rst_n = r; v.bi = bi; v.br = br; v.spd = s; v.ncyc = n; v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic model_reset();
    m_mode    = M_INIT;
    m_left    = INIT;
    m_elapsed = 0;
    m_spd     = 0;
    m_hz      = 1'b0;
    m_tick    = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_deb[b]     = 1'b0;
      m_run[b]     = 0;
      m_hist[b][0] = 1'b0;
      m_hist[b][1] = 1'b0;
      m_ev[b]      = 1'b0;
    end
  endtask

  // One clock edge of the model, using the inputs present before the edge.
  task automatic model_edge();
    logic ei, er, syn;
    logic raw [2];
    if (!sys_rst_n) begin
      model_reset();
      return;
    end
    ei = m_ev[0];
    er = m_ev[1];
    m_tick = 1'b0;
    if (ei) begin
      m_mode = M_INIT; m_left = INIT; m_elapsed = 0; m_hz = 1'b0; m_spd = int'(speed_sel);
    end else if (m_mode == M_INIT) begin
      m_spd  = int'(speed_sel);
      m_left = m_left - 1;
      if (m_left == 0) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      m_elapsed = m_elapsed + 1;
      if (m_elapsed == (DIV >> m_spd) / 2) begin
        m_elapsed = 0;
        m_hz      = ~m_hz;
        m_tick    = m_hz;
        m_spd     = int'(speed_sel);
      end
      if (er) m_mode = M_PAUSE;
    end else begin
      if (er) m_mode = M_RUN;
    end
    raw[0] = btn_init;
    raw[1] = btn_run;
    for (int b = 0; b < 2; b++) begin
      syn     = m_hist[b][1];
      m_ev[b] = 1'b0;
      if (syn != m_deb[b]) begin
        m_run[b] = m_run[b] + 1;
        if (m_run[b] == DB) begin
          m_deb[b] = syn;
          m_run[b] = 0;
          m_ev[b]  = syn;
        end
      end else begin
        m_run[b] = 0;
      end
      m_hist[b][1] = m_hist[b][0];
      m_hist[b][0] = raw[b];
    end
  endtask

  // Advance one clock, update the model and compare all outputs.
  task automatic step();
    logic [3:0] got, exp;
    @(posedge clk50);
    model_edge();
    @(negedge clk50);
    cyc = cyc + 1;
    got = {sys_init_ctrl, hertz_clk, tick, running};
    exp = {(m_mode == M_INIT), m_hz, m_tick, (m_mode == M_RUN)};
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL model cycle %0d init/hz/tick/run got %b required %b", cyc, got, exp);
    end
  endtask

  initial begin
    logic [3:0] got;
    int         bi_left, br_left;
    sys_rst_n = 1'b0;
    btn_init  = 1'b0;
    btn_run   = 1'b0;
    speed_sel = 2'd0;
    model_reset();

    // reset, init hold, first rise and full period at speed 0
    add(1'b0, 1'b0, 1'b0, 2'd0, 2, 4'b1000);
    add(1'b1, 1'b0, 1'b0, 2'd0, 2, 4'b1000);
    add(1'b1, 1'b0, 1'b0, 2'd0, 1, 4'b0001);
    add(1'b1, 1'b0, 1'b0, 2'd0, 7, 4'b0001);
    add(1'b1, 1'b0, 1'b0, 2'd0, 1, 4'b0111);
    add(1'b1, 1'b0, 1'b0, 2'd0, 1, 4'b0101);
    add(1'b1, 1'b0, 1'b0, 2'd0, 7, 4'b0001);
    add(1'b1, 1'b0, 1'b0, 2'd0, 8, 4'b0111);
    // speed change mid-half-period, then fastest rate
    add(1'b1, 1'b0, 1'b0, 2'd2, 3, 4'b0101);
    add(1'b1, 1'b0, 1'b0, 2'd2, 5, 4'b0001);
    add(1'b1, 1'b0, 1'b0, 2'd2, 1, 4'b0001);
    add(1'b1, 1'b0, 1'b0, 2'd2, 1, 4'b0111);
    add(1'b1, 1'b0, 1'b0, 2'd3, 2, 4'b0001);
    add(1'b1, 1'b0, 1'b0, 2'd3, 1, 4'b0111);
    add(1'b1, 1'b0, 1'b0, 2'd3, 1, 4'b0001);
    add(1'b1, 1'b0, 1'b0, 2'd3, 1, 4'b0111);
    add(1'b1, 1'b0, 1'b0, 2'd0, 1, 4'b0001);
    // debounce: short glitch ignored, long press pauses, second press resumes
    add(1'b1, 1'b0, 1'b1, 2'd0, 3, 4'b0001);
    add(1'b1, 1'b0, 1'b0, 2'd0, 4, 4'b0001);
    add(1'b1, 1'b0, 1'b1, 2'd0, 6, 4'b0101);
    add(1'b1, 1'b0, 1'b1, 2'd0, 1, 4'b0100);
    add(1'b1, 1'b0, 1'b1, 2'd0, 3, 4'b0100);
    add(1'b1, 1'b0, 1'b0, 2'd0, 10, 4'b0100);
    add(1'b1, 1'b0, 1'b1, 2'd0, 6, 4'b0100);
    add(1'b1, 1'b0, 1'b1, 2'd0, 1, 4'b0101);
    add(1'b1, 1'b0, 1'b0, 2'd0, 1, 4'b0101);
    add(1'b1, 1'b0, 1'b0, 2'd0, 1, 4'b0001);
    // init press during RUN with hertz_clk high
    add(1'b1, 1'b0, 1'b0, 2'd0, 8, 4'b0111);
    add(1'b1, 1'b1, 1'b0, 2'd0, 6, 4'b0101);
    add(1'b1, 1'b1, 1'b0, 2'd0, 1, 4'b1000);
    add(1'b1, 1'b0, 1'b0, 2'd0, 2, 4'b1000);
    add(1'b1, 1'b0, 1'b0, 2'd0, 1, 4'b0001);
    // simultaneous init and run events: init wins, no PAUSE afterwards
    add(1'b1, 1'b0, 1'b0, 2'd0, 8, 4'b0111);
    add(1'b1, 1'b1, 1'b1, 2'd0, 6, 4'b0101);
    add(1'b1, 1'b1, 1'b1, 2'd0, 1, 4'b1000);
    add(1'b1, 1'b0, 1'b0, 2'd0, 3, 4'b0001);
    // reset while paused with hertz_clk high
    add(1'b1, 1'b0, 1'b0, 2'd0, 8, 4'b0111);
    add(1'b1, 1'b0, 1'b1, 2'd0, 7, 4'b0100);
    add(1'b1, 1'b0, 1'b0, 2'd0, 4, 4'b0100);
    add(1'b0, 1'b0, 1'b0, 2'd0, 1, 4'b1000);
    add(1'b1, 1'b0, 1'b0, 2'd0, 3, 4'b0001);

    foreach (tbl[i]) begin
      sys_rst_n = tbl[i].rst_n;
      btn_init  = tbl[i].bi;
      btn_run   = tbl[i].br;
      speed_sel = tbl[i].spd;
      for (int k = 0; k < tbl[i].ncyc; k++) step();
      got = {sys_init_ctrl, hertz_clk, tick, running};
      n_vec = n_vec + 1;
      if (got !== tbl[i].exp) begin
        n_bad = n_bad + 1;
        $display("FAIL table[%0d] init/hz/tick/run got %b required %b", i, got, tbl[i].exp);
      end
    end

    // randomized buttons, speed and occasional reset against the model
    bi_left = 0;
    br_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (bi_left == 0) begin
        btn_init = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
        bi_left  = $urandom_range(1, 10);
      end
      if (br_left == 0) begin
        btn_run = $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0;
        br_left = $urandom_range(1, 14);
      end
      bi_left = bi_left - 1;
      br_left = br_left - 1;
      if ($urandom_range(0, 39) == 0) speed_sel = 2'($urandom_range(0, 3));
      sys_rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
